// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard_ctrl pipeline interlock controller.
package hazard_pkg;

  // Tags store register addresses at this fixed width so one struct serves any RW up to 8.
  localparam int TAG_RW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    DRAIN     = 2'b01,
    TRAP_WAIT = 2'b10
  } ctrl_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_RW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_tag_t;

  typedef struct packed {
    stage_tag_t        tag;
    logic [TAG_RW-1:0] rs1;
    logic [TAG_RW-1:0] rs2;
  } ex_tag_t;

  localparam stage_tag_t TAG_NONE = stage_tag_t'({$bits(stage_tag_t){1'b0}});
  localparam ex_tag_t    EX_NONE  = ex_tag_t'({$bits(ex_tag_t){1'b0}});

  // Valid slot whose non-zero rd equals src; x0 never creates a dependency.
  function automatic logic tag_match(input stage_tag_t t, input logic [TAG_RW-1:0] src);
    return t.valid && (t.rd != {TAG_RW{1'b0}}) && (t.rd == src);
  endfunction

  function automatic logic tag_writes(input stage_tag_t t, input logic [TAG_RW-1:0] src);
    return tag_match(t, src) && t.reg_write;
  endfunction

  // The youngest producer (MEM) wins over the older one (WB).
  function automatic fwd_sel_e fwd_pick(input stage_tag_t mem_t, input stage_tag_t wb_t,
                                        input logic [TAG_RW-1:0] src);
    fwd_sel_e sel;
    if (tag_writes(mem_t, src)) begin
      sel = FWD_MEM;
    end else if (tag_writes(wb_t, src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow pipeline of destination-register tags for the EX, MEM and WB stages.
module hazard_tag_pipe
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic       bubble,
  input  ex_tag_t    id_tag,
  output ex_tag_t    ex_tag,
  output stage_tag_t mem_tag,
  output stage_tag_t wb_tag
);

  ex_tag_t    ex_d, ex_q;
  stage_tag_t mem_d, mem_q;
  stage_tag_t wb_d, wb_q;

  // Shift EX->MEM->WB unless frozen; EX takes the issuing instruction or a bubble.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q.tag;
      if (bubble) begin
        ex_d = EX_NONE;
      end else begin
        ex_d = id_tag;
      end
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end
  end

  // Tag slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_NONE;
      mem_q <= TAG_NONE;
      wb_q  <= TAG_NONE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_tag  = ex_q;
  assign mem_tag = mem_q;
  assign wb_tag  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: stall, flush, forwarding-select and trap sequencing for the
// 5-stage core. Define HAZARD_FWD_EN to enable EX forwarding; otherwise RAW hazards stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RW           = 5,
  parameter int TRAP_TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_trap,
  input  logic          ex_branch_taken,
  input  logic          mem_access,
  input  logic          dmem_ready,
  input  logic          trap_ack,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          freeze,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          trap_req,
  output logic          busy
);

  localparam int            CW       = (TRAP_TIMEOUT > 1) ? $clog2(TRAP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TRAP_TIMEOUT > 0) ? TRAP_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  ctrl_state_e state_d, state_q;
  logic        ack_flush_d, ack_flush_q;
  logic [CW-1:0] wait_cnt_d, wait_cnt_q;

  ex_tag_t    ex_tag;
  stage_tag_t mem_tag, wb_tag;
  ex_tag_t    id_tag_s;
  logic [TAG_RW-1:0] id_rs1_s, id_rs2_s;
  logic freeze_s, branch_s, load_use_s, raw_stall_s, pipe_empty_s, timeout_s, issue_s;
  fwd_sel_e fwd_a_s, fwd_b_s;
  logic unused_tag_bits_s;

  hazard_tag_pipe u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .freeze  (freeze_s),
    .bubble  (!issue_s),
    .id_tag  (id_tag_s),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag)
  );

  // Hazard detection and forwarding selection from the tag slots and the ID fields.
  always_comb begin
    id_rs1_s = TAG_RW'(id_rs1);
    id_rs2_s = TAG_RW'(id_rs2);
    id_tag_s.tag.valid     = id_valid;
    id_tag_s.tag.rd        = TAG_RW'(id_rd);
    id_tag_s.tag.reg_write = id_reg_write;
    id_tag_s.tag.mem_read  = id_mem_read;
    id_tag_s.rs1           = id_rs1_s;
    id_tag_s.rs2           = id_rs2_s;

    freeze_s     = mem_tag.valid && mem_access && !dmem_ready;
    branch_s     = ex_branch_taken && !freeze_s;
    pipe_empty_s = !ex_tag.tag.valid && !mem_tag.valid && !wb_tag.valid;
    timeout_s    = (TRAP_TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);
    load_use_s   = id_valid && ex_tag.tag.mem_read &&
                   ((id_use_rs1 && tag_match(ex_tag.tag, id_rs1_s)) ||
                    (id_use_rs2 && tag_match(ex_tag.tag, id_rs2_s)));
`ifdef HAZARD_FWD_EN
    raw_stall_s = load_use_s;
    fwd_a_s     = fwd_pick(mem_tag, wb_tag, ex_tag.rs1);
    fwd_b_s     = fwd_pick(mem_tag, wb_tag, ex_tag.rs2);
`else
    // WB is not checked: the register file writes through to the read ports.
    raw_stall_s = load_use_s || (id_valid &&
                  ((id_use_rs1 && (tag_writes(ex_tag.tag, id_rs1_s) || tag_writes(mem_tag, id_rs1_s))) ||
                   (id_use_rs2 && (tag_writes(ex_tag.tag, id_rs2_s) || tag_writes(mem_tag, id_rs2_s)))));
    fwd_a_s     = FWD_RF;
    fwd_b_s     = FWD_RF;
`endif
  end

  assign unused_tag_bits_s = ^{ex_tag.tag.reg_write, mem_tag.mem_read, wb_tag.mem_read,
                               ex_tag.rs1, ex_tag.rs2};

  // Controller state, pending post-ack flush and trap wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ack_flush_q <= 1'b0;
      wait_cnt_q  <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      ack_flush_q <= ack_flush_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ack_flush_d = 1'b0;
    wait_cnt_d  = CNT_ZERO;
    case (state_q)
      RUN: begin
        if (freeze_s) begin
          ack_flush_d = ack_flush_q;
        end else if (ack_flush_q) begin
          state_d = RUN;
        end else if (branch_s) begin
          state_d = RUN;
        end else if (id_valid && id_trap) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (freeze_s) begin
          state_d = DRAIN;
        end else if (branch_s) begin
          state_d = RUN;
        end else if (pipe_empty_s) begin
          state_d = TRAP_WAIT;
        end else begin
          state_d = DRAIN;
        end
      end
      TRAP_WAIT: begin
        if (trap_ack) begin
          state_d     = RUN;
          ack_flush_d = 1'b1;
        end else if (timeout_s) begin
          // No flush: the trap instruction is still in IF/ID and decodes again.
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output decode by state, following the hazard priority order.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    freeze     = 1'b0;
    trap_req   = 1'b0;
    issue_s    = 1'b0;
    fwd_a_sel  = fwd_a_s;
    fwd_b_sel  = fwd_b_s;
    busy       = (state_q != RUN);
    case (state_q)
      RUN: begin
        if (freeze_s) begin
          freeze     = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
        end else if (ack_flush_q) begin
          ifid_flush = 1'b1;
        end else if (branch_s) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if ((id_valid && id_trap) || raw_stall_s) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else begin
          issue_s = id_valid;
        end
      end
      DRAIN: begin
        if (freeze_s) begin
          freeze     = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
        end else if (branch_s) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      TRAP_WAIT: begin
        trap_req   = 1'b1;
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
